// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imm_pkg
//  Brief    : Opcode constants, immediate format enum and stage payload type
//             shared by the immediate-generation pipeline.
//  Revision : 1.0
// ============================================================================
package imm_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE    = 3'd0,
        FMT_I       = 3'd1,
        FMT_I_SHAMT = 3'd2,
        FMT_S       = 3'd3,
        FMT_B       = 3'd4,
        FMT_U       = 3'd5,
        FMT_J       = 3'd6,
        FMT_CSR     = 3'd7
    } imm_fmt_t;

    // The XLEN-wide immediate travels beside this struct, since a package
    // type cannot follow the pipeline's width parameter.
    typedef struct packed {
        imm_fmt_t fmt;
        logic     illegal;
    } imm_stage_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
//  Module   : imm_decode
//  Brief    : Combinational RV immediate decoder, XLEN-parametrised.
//  Revision : 1.0
// ============================================================================
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // Every format is built as a 32-bit value whose bit 31 is the wanted
    // extension bit, so a single signed cast widens it to XLEN.
    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt_o = FMT_I_SHAMT;
                    if (XLEN == 32) begin
                        imm32     = {27'd0, inst_i[24:20]};
                        illegal_o = inst_i[25];
                    end else begin
                        imm32 = {26'd0, inst_i[25:20]};
                    end
                end else begin
                    fmt_o = FMT_I;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt_o = FMT_I;
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm32 = {inst_i[31:12], 12'd0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                         inst_i[20], inst_i[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    fmt_o = FMT_CSR;
                    imm32 = {27'd0, inst_i[19:15]};
                end
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule
`default_nettype wire

// File: rtl/immgen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : immgen_pipe
//  Brief    : Valid/ready pipeline (1 or 2 stages) around the immediate decoder.
//  Revision : 1.0
// ============================================================================
module immgen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_t        out_fmt,
    output logic            out_illegal
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("immgen_pipe: XLEN must be 32 or 64");
    end
    if (!(LATENCY == 1 || LATENCY == 2)) begin : g_bad_latency
        $error("immgen_pipe: LATENCY must be 1 or 2");
    end

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic            dec_illegal;
    imm_stage_t      dec_meta;

    imm_decode #(
        .XLEN      (XLEN)
    ) u_decode (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    assign dec_meta = '{fmt: dec_fmt, illegal: dec_illegal};

    logic            s1_valid_q;
    logic            s1_valid_d;
    logic [XLEN-1:0] s1_imm_q;
    imm_stage_t      s1_meta_q;
    logic            s1_adv;
    logic            accept;

    logic            last_valid;
    logic [XLEN-1:0] last_imm;
    imm_stage_t      last_meta;

    assign in_ready = rst_n && !flush && (!s1_valid_q || s1_adv);
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // Payload registers carry no reset: only valid bits are squashed.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_imm_q  <= dec_imm;
            s1_meta_q <= dec_meta;
        end
    end

    if (LATENCY == 2) begin : g_two_stage
        logic            s2_valid_q;
        logic            s2_valid_d;
        logic [XLEN-1:0] s2_imm_q;
        imm_stage_t      s2_meta_q;
        logic            s2_adv;

        assign s2_adv = !s2_valid_q || out_ready;
        assign s1_adv = s2_adv;

        always_comb begin
            s2_valid_d = s2_valid_q;
            if (flush) begin
                s2_valid_d = 1'b0;
            end else if (s2_adv) begin
                s2_valid_d = s1_valid_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s2_valid_d;
            end
        end

        always_ff @(posedge clk) begin
            if (s1_valid_q && s2_adv && !flush) begin
                s2_imm_q  <= s1_imm_q;
                s2_meta_q <= s1_meta_q;
            end
        end

        assign last_valid = s2_valid_q;
        assign last_imm   = s2_imm_q;
        assign last_meta  = s2_meta_q;
    end else begin : g_one_stage
        assign s1_adv     = out_ready;
        assign last_valid = s1_valid_q;
        assign last_imm   = s1_imm_q;
        assign last_meta  = s1_meta_q;
    end

    // Data fields are forced to neutral values while reset is held.
    assign out_valid   = last_valid;
    assign out_imm     = rst_n ? last_imm : '0;
    assign out_fmt     = rst_n ? last_meta.fmt : FMT_NONE;
    assign out_illegal = rst_n && last_meta.illegal;

endmodule
`default_nettype wire

// File: tb/tb_immgen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_immgen_pipe
//  Brief    : Directed bench for immgen_pipe (XLEN 32/64, LATENCY 1/2).
//  Revision : 1.0
// ============================================================================
module tb_immgen_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic        a_iv = 1'b0, a_or = 1'b0, a_ir, a_ov, a_ill;
    logic [31:0] a_inst = '0, a_imm;
    imm_fmt_t    a_fmt;

    logic        b_iv = 1'b0, b_or = 1'b0, b_ir, b_ov, b_ill;
    logic [31:0] b_inst = '0;
    logic [63:0] b_imm;
    imm_fmt_t    b_fmt;

    logic        c_iv = 1'b0, c_or = 1'b0, c_ir, c_ov, c_ill;
    logic [31:0] c_inst = '0, c_imm;
    imm_fmt_t    c_fmt;

    immgen_pipe #(.XLEN(32), .LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_inst(a_inst),
        .out_valid(a_ov), .out_ready(a_or),
        .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill)
    );

    immgen_pipe #(.XLEN(64), .LATENCY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_inst(b_inst),
        .out_valid(b_ov), .out_ready(b_or),
        .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_ill)
    );

    immgen_pipe #(.XLEN(32), .LATENCY(2)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(c_iv), .in_ready(c_ir), .in_inst(c_inst),
        .out_valid(c_ov), .out_ready(c_or),
        .out_imm(c_imm), .out_fmt(c_fmt), .out_illegal(c_ill)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addi(input int k);
        logic [11:0] imm12;
        imm12 = 12'(k);
        return {imm12, 20'h00093};
    endfunction

    // One word through a LATENCY=1 instance (a: XLEN=32, b: XLEN=64).
    task automatic dec_vec(input bit use_b, input string name, input logic [31:0] inst,
                           input logic [63:0] eimm, input imm_fmt_t efmt, input logic eill);
        @(posedge clk); #1;
        if (use_b) begin b_iv = 1'b1; b_inst = inst; b_or = 1'b1; end
        else       begin a_iv = 1'b1; a_inst = inst; a_or = 1'b1; end
        @(negedge clk);
        check({name, " in_ready"}, use_b ? b_ir : a_ir, 64'd1);
        @(posedge clk); #1;
        a_iv = 1'b0;
        b_iv = 1'b0;
        @(negedge clk);
        check({name, " out_valid"}, use_b ? b_ov : a_ov, 64'd1);
        check({name, " imm"}, use_b ? b_imm : {32'd0, a_imm}, eimm);
        check({name, " fmt"}, use_b ? 64'(b_fmt) : 64'(a_fmt), 64'(efmt));
        check({name, " illegal"}, use_b ? b_ill : a_ill, 64'(eill));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;
        logic held_v;
        logic [31:0] held;

        // Reset state
        #2;
        check("rst out_valid", a_ov, 64'd0);
        check("rst in_ready", a_ir, 64'd0);
        check("rst out_imm", a_imm, 64'd0);
        check("rst out_fmt", 64'(a_fmt), 64'(FMT_NONE));
        check("rst out_illegal", a_ill, 64'd0);
        check("rst out_imm64", b_imm, 64'd0);
        check("rst c in_ready", c_ir, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst a in_ready", a_ir, 64'd1);
        check("post-rst c in_ready", c_ir, 64'd1);

        // Decode vectors, XLEN=32
        dec_vec(1'b0, "addi -1",   32'hFFF00093, 64'hFFFFFFFF, FMT_I,       1'b0);
        dec_vec(1'b0, "beq -4",    32'hFE000EE3, 64'hFFFFFFFC, FMT_B,       1'b0);
        dec_vec(1'b0, "srai 3",    32'h4030D093, 64'h00000003, FMT_I_SHAMT, 1'b0);
        dec_vec(1'b0, "slli 32",   32'h02009093, 64'h00000000, FMT_I_SHAMT, 1'b1);
        dec_vec(1'b0, "sw -8",     32'hFE20AC23, 64'hFFFFFFF8, FMT_S,       1'b0);
        dec_vec(1'b0, "jal 2048",  32'h001000EF, 64'h00000800, FMT_J,       1'b0);
        dec_vec(1'b0, "csrrwi 31", 32'h300FD0F3, 64'h0000001F, FMT_CSR,     1'b0);
        dec_vec(1'b0, "auipc",     32'h12345097, 64'h12345000, FMT_U,       1'b0);
        dec_vec(1'b0, "bad op32",  32'h0000007F, 64'h00000000, FMT_NONE,    1'b1);

        // Decode vectors, XLEN=64
        dec_vec(1'b1, "lui64",     32'h800000B7, 64'hFFFFFFFF80000000, FMT_U,       1'b0);
        dec_vec(1'b1, "bad op64",  32'h0000007F, 64'h0,                FMT_NONE,    1'b1);
        dec_vec(1'b1, "slli64 32", 32'h02009093, 64'h20,               FMT_I_SHAMT, 1'b0);
        dec_vec(1'b1, "addi64 -1", 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, FMT_I,       1'b0);

        // Back-to-back throughput, LATENCY=1
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            a_or   = 1'b1;
            a_iv   = (k < 3);
            a_inst = addi(10 + k);
            @(negedge clk);
            if (k < 3) check("b2b in_ready", a_ir, 64'd1);
            if (k > 0) begin
                check("b2b out_valid", a_ov, 64'd1);
                check("b2b imm", a_imm, 64'(10 + k - 1));
            end
        end

        // Stall on LATENCY=1 with an illegal shift, then reset mid-stream
        @(posedge clk); #1;
        a_or = 1'b0; a_iv = 1'b1; a_inst = 32'h02109093;
        @(posedge clk); #1;
        a_inst = addi(22);
        @(negedge clk);
        check("stall1 out_valid", a_ov, 64'd1);
        check("stall1 in_ready", a_ir, 64'd0);
        check("stall1 imm", a_imm, 64'd1);
        check("stall1 illegal", a_ill, 64'd1);
        @(negedge clk);
        check("stall1 stable imm", a_imm, 64'd1);
        check("stall1 stable fmt", 64'(a_fmt), 64'(FMT_I_SHAMT));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", a_ov, 64'd0);
        check("midrst in_ready", a_ir, 64'd0);
        check("midrst imm", a_imm, 64'd0);
        check("midrst fmt", 64'(a_fmt), 64'(FMT_NONE));
        check("midrst illegal", a_ill, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_iv = 1'b0;
        a_or = 1'b1;
        #1;
        check("after midrst in_ready", a_ir, 64'd1);
        @(negedge clk);
        check("after midrst discarded", a_ov, 64'd0);

        // LATENCY=2 stream of 5 words, out_ready low for cycles 1..3
        sent = 0;
        got = 0;
        held_v = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(posedge clk); #1;
            c_iv   = (sent < 5);
            c_inst = addi(sent + 1);
            c_or   = !(cyc >= 1 && cyc <= 3);
            @(negedge clk);
            if (held_v) check("c stall stable", c_imm, 64'(held));
            if (cyc == 3) begin
                check("c in_ready stalled", c_ir, 64'd0);
                check("c accepted before stall", 64'(sent), 64'd2);
            end
            if (c_ov && c_or) begin
                check("c order", c_imm, 64'(got + 1));
                got++;
            end
            held_v = c_ov && !c_or;
            held   = c_imm;
            if (c_iv && c_ir) sent++;
        end
        check("c delivered", 64'(got), 64'd5);

        // Flush with two words in flight and in_valid high
        @(posedge clk); #1;
        c_or = 1'b0; c_iv = 1'b1; c_inst = addi(31);
        @(posedge clk); #1;
        c_inst = addi(32);
        @(posedge clk); #1;
        flush = 1'b1;
        c_inst = addi(33);
        @(negedge clk);
        check("flush pre out_valid", c_ov, 64'd1);
        check("flush in_ready", c_ir, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        c_iv = 1'b0;
        c_or = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush out_valid", c_ov, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/immgen_pipe.md
IMMGEN_PIPE -- requirements
Module: immgen_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64; any other value SHALL fail elaboration.
REQ-002 Parameter LATENCY, default 1: number of register stages; legal values 1 and 2; any other value SHALL fail elaboration.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 flush  in  1  synchronous squash of every in-flight entry.
REQ-006 in_valid  in  1  in_inst is valid this cycle.
REQ-007 in_ready  out  1  block accepts in_inst this cycle.
REQ-008 in_inst  in  32  instruction word.
REQ-009 out_valid  out  1  out_* fields are valid.
REQ-010 out_ready  in  1  consumer accepts the output this cycle.
REQ-011 out_imm  out  XLEN  decoded immediate.
REQ-012 out_fmt  out  3  immediate format code (imm_fmt_t).
REQ-013 out_illegal  out  1  opcode, or shift amount for XLEN, not supported.

Function
REQ-014 Transfer SHALL occur on in_valid&&in_ready (input) and on out_valid&&out_ready (output).
REQ-015 An accepted word SHALL appear on out_* exactly LATENCY cycles after acceptance, provided no stall occurs.
REQ-016 Each stage SHALL hold a valid bit; in_ready = !stage1_valid || stage1 advancing, evaluated combinationally back from out_ready; out_valid SHALL be the last stage's valid bit.
REQ-017 With out_ready held high, one word per cycle SHALL be sustained; under a stall, no word SHALL be lost, duplicated or reordered, and out_* SHALL stay stable while out_valid&&!out_ready.
REQ-018 Decode from opcode inst[6:0]:
- OP-IMM (0010011), LOAD (0000011), JALR (1100111): fmt I, sign-extend inst[31:20].
- OP-IMM with funct3 001/101: fmt I_SHAMT, zero-extend inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64); XLEN=32 with inst[25]=1 SHALL set illegal.
- STORE (0100011): fmt S, sign-extend {inst[31:25],inst[11:7]}.
- BRANCH (1100011): fmt B, sign-extend {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- LUI (0110111), AUIPC (0010111): fmt U, {inst[31:12],12'b0} sign-extended to XLEN.
- JAL (1101111): fmt J, sign-extend {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- SYSTEM (1110011) with funct3 1xx: fmt CSR, zero-extend inst[19:15].
- Any other opcode: fmt NONE, imm 0, illegal 1.
REQ-019 Decode SHALL be combinational ahead of stage 1; stage 2, when present, SHALL only register stage-1 outputs.
REQ-020 flush SHALL clear all valid bits at the next edge, overriding any acceptance in that cycle; in_ready SHALL be 0 while flush is high.
REQ-021 Flush and reset SHALL clear only valid bits and SHALL leave data registers unchanged.

Reset
REQ-022 While rst_n is low: out_valid=0, in_ready=0, all valid bits 0, out_imm=0, out_fmt=NONE, out_illegal=0.
REQ-023 in_ready SHALL rise in the first cycle after rst_n deasserts; reset mid-stream SHALL discard all in-flight words.

Structure
REQ-024 Package imm_pkg SHALL hold the opcode constants, the imm_fmt_t enum (NONE, I, I_SHAMT, S, B, U, J, CSR) and a stage payload struct.
REQ-025 Decode SHALL be a sub-module, imm_decode (pure combinational, XLEN-parametrised); immgen_pipe SHALL instantiate it once together with the stage registers.

Verification
REQ-026 XLEN=32, LATENCY=1: inst 0xFFF00093 -> one cycle later out_imm=0xFFFFFFFF, fmt I, illegal 0.
REQ-027 inst 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt B; inst 0x4030D093 (srai 3) -> out_imm=0x00000003, fmt I_SHAMT.
REQ-028 XLEN=64: inst 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000, fmt U; inst 0x0000007F -> out_imm 0, fmt NONE, illegal 1.
REQ-029 LATENCY=2, stream of 5 words, out_ready low for 3 cycles -> in_ready falls after 2 accepted, outputs stable, all 5 delivered in order.
REQ-030 flush with 2 words in flight and in_valid high -> next cycle out_valid=0, nothing accepted; rst_n low mid-stream -> out_valid falls immediately with no clock edge.
